// File: rtl/fpu_issue_sched_pkg.sv
// Shared encodings for the FPU issue scheduler: FSM states, write-port source select,
// default watchdog limit and the saturating increment used by the optional perf counters.
package fpu_issue_sched_pkg;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_BUSY = 1'b1
    } sched_state_e;

    localparam logic WB_SEL_FPU = 1'b1;
    localparam logic WB_SEL_INT = 1'b0;

    localparam int SCHED_TIMEOUT_DEF = 64;
    localparam int PERF_W            = 32;

    // Increment unless disabled or already pinned at all-ones.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        logic [PERF_W-1:0] r;
        r = v;
        if (en && (v != '1)) begin
            r = v + PERF_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_issue_sched_fp_hazard_chk.sv
// Combinational RAW/WAW detection of the issuing instruction against the single in-flight FPU op.
// f0 is an ordinary FP register, so no register index is exempt.
module fp_hazard_chk (
    input  logic       pend_v,
    input  logic [4:0] pend_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rs3,
    input  logic [2:0] id_use,
    input  logic       id_fp_we,
    input  logic [4:0] id_fp_rd,
    output logic       raw,
    output logic       waw
);

    logic [2:0] src_hit;

    always_comb begin
        src_hit[0] = id_use[0] & (id_rs1 == pend_rd);
        src_hit[1] = id_use[1] & (id_rs2 == pend_rd);
        src_hit[2] = id_use[2] & (id_rs3 == pend_rd);
        raw        = pend_v & (|src_hit);
        waw        = pend_v & id_fp_we & (id_fp_rd == pend_rd);
    end

endmodule

// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler and FP write-port arbiter with a BUSY-state watchdog.
// Define FPU_SCHED_PERF_EN to add saturating issue/stall/write-port-conflict counters.
module fpu_issue_sched
    import fpu_issue_sched_pkg::*;
#(
    parameter int TIMEOUT = SCHED_TIMEOUT_DEF,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_fp_op,
    input  logic [4:0]  id_fp_rd,
    input  logic        id_fp_we,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rs3,
    input  logic [2:0]  id_use,
    input  logic        flush,
    input  logic        fpu_busy,
    input  logic        fpu_done,
    input  logic        int_wb_req,
    input  logic [4:0]  int_wb_rd,
    output logic        issue,
    output logic        stall,
    output logic        wb_fp_we,
    output logic [4:0]  wb_fp_rd,
    output logic        wb_sel_fpu,
    output logic        int_wb_gnt,
    output logic        wd_err
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [31:0] perf_issue,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_wb_conflict
`endif
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e     state_q,  state_d;
    logic             pend_v_q, pend_v_d;
    logic [4:0]       pend_rd_q, pend_rd_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             wd_err_q, wd_err_d;

    logic raw;
    logic waw;
    logic struct_haz;
    logic fpu_wb;
    logic live;

    fp_hazard_chk u_hazard (
        .pend_v   (pend_v_q),
        .pend_rd  (pend_rd_q),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .id_rs3   (id_rs3),
        .id_use   (id_use),
        .id_fp_we (id_fp_we),
        .id_fp_rd (id_fp_rd),
        .raw      (raw),
        .waw      (waw)
    );

    // Outputs are forced low while rst is held so the reset value is visible immediately.
    always_comb begin
        live       = ~rst;
        struct_haz = id_fp_op & (((state_q == SCHED_BUSY) & ~fpu_done) |
                                 (fpu_busy & (state_q == SCHED_IDLE)));
        stall      = live & id_valid & ~flush & (raw | waw | struct_haz);
        issue      = live & id_valid & id_fp_op & ~stall & ~flush;
        fpu_wb     = live & (state_q == SCHED_BUSY) & fpu_done;
        int_wb_gnt = live & int_wb_req & ~fpu_wb;
        wb_fp_we   = fpu_wb | int_wb_gnt;
        wb_sel_fpu = fpu_wb ? WB_SEL_FPU : WB_SEL_INT;
        wb_fp_rd   = fpu_wb ? pend_rd_q : (int_wb_gnt ? int_wb_rd : 5'd0);
    end

    always_comb begin
        state_d   = state_q;
        pend_v_d  = pend_v_q;
        pend_rd_d = pend_rd_q;
        wd_cnt_d  = wd_cnt_q;
        wd_err_d  = wd_err_q;
        case (state_q)
            SCHED_IDLE: begin
                if (issue) begin
                    state_d   = SCHED_BUSY;
                    pend_v_d  = 1'b1;
                    pend_rd_d = id_fp_rd;
                    wd_cnt_d  = '0;
                end
            end
            SCHED_BUSY: begin
                if (fpu_done) begin
                    // Back-to-back: a new op may enter on the completion cycle.
                    if (issue) begin
                        pend_v_d  = 1'b1;
                        pend_rd_d = id_fp_rd;
                        wd_cnt_d  = '0;
                    end else begin
                        state_d  = SCHED_IDLE;
                        pend_v_d = 1'b0;
                        wd_cnt_d = '0;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    // Abandon the op; a late fpu_done lands in IDLE and is ignored.
                    state_d  = SCHED_IDLE;
                    pend_v_d = 1'b0;
                    wd_cnt_d = '0;
                    wd_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = SCHED_IDLE;
                pend_v_d = 1'b0;
                wd_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SCHED_IDLE;
            pend_v_q  <= 1'b0;
            pend_rd_q <= 5'd0;
            wd_cnt_q  <= '0;
            wd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_v_q  <= pend_v_d;
            pend_rd_q <= pend_rd_d;
            wd_cnt_q  <= wd_cnt_d;
            wd_err_q  <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;

`ifdef FPU_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_issue_q,       perf_issue_d;
    logic [PERF_W-1:0] perf_stall_q,       perf_stall_d;
    logic [PERF_W-1:0] perf_wb_conflict_q, perf_wb_conflict_d;

    always_comb begin
        perf_issue_d       = sat_inc(perf_issue_q, issue);
        perf_stall_d       = sat_inc(perf_stall_q, stall);
        perf_wb_conflict_d = sat_inc(perf_wb_conflict_q, int_wb_req & ~int_wb_gnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q       <= '0;
            perf_stall_q       <= '0;
            perf_wb_conflict_q <= '0;
        end else begin
            perf_issue_q       <= perf_issue_d;
            perf_stall_q       <= perf_stall_d;
            perf_wb_conflict_q <= perf_wb_conflict_d;
        end
    end

    assign perf_issue       = perf_issue_q;
    assign perf_stall       = perf_stall_q;
    assign perf_wb_conflict = perf_wb_conflict_q;
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: hazard vector table plus a write-back scoreboard.
module tb_fpu_issue_sched;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_fp_op, id_fp_we, flush, fpu_busy, fpu_done, int_wb_req;
    logic [4:0] id_fp_rd, id_rs1, id_rs2, id_rs3, int_wb_rd;
    logic [2:0] id_use;
    logic       issue, stall, wb_fp_we, wb_sel_fpu, int_wb_gnt, wd_err;
    logic [4:0] wb_fp_rd;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0] perf_issue, perf_stall, perf_wb_conflict;
`endif

    always #10 clk = ~clk;

    fpu_issue_sched #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_fp_op   (id_fp_op),
        .id_fp_rd   (id_fp_rd),
        .id_fp_we   (id_fp_we),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs3     (id_rs3),
        .id_use     (id_use),
        .flush      (flush),
        .fpu_busy   (fpu_busy),
        .fpu_done   (fpu_done),
        .int_wb_req (int_wb_req),
        .int_wb_rd  (int_wb_rd),
        .issue      (issue),
        .stall      (stall),
        .wb_fp_we   (wb_fp_we),
        .wb_fp_rd   (wb_fp_rd),
        .wb_sel_fpu (wb_sel_fpu),
        .int_wb_gnt (int_wb_gnt),
        .wd_err     (wd_err)
`ifdef FPU_SCHED_PERF_EN
        ,
        .perf_issue       (perf_issue),
        .perf_stall       (perf_stall),
        .perf_wb_conflict (perf_wb_conflict)
`endif
    );

    typedef struct {
        logic       v, fp_op, fp_we;
        logic [4:0] rd, rs1, rs2, rs3;
        logic [2:0] use_m;
        logic       fl, busy;
        logic       exp_issue, exp_stall;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic       sel;
    } wb_exp_t;

    vec_t    vecs[14];
    wb_exp_t sb[$];
    wb_exp_t e;
    int      n_chk  = 0;
    int      n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic quiet();
        id_valid = 0; id_fp_op = 0; id_fp_we = 0; id_fp_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_use = 0;
        flush = 0; fpu_busy = 0; fpu_done = 0; int_wb_req = 0; int_wb_rd = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        quiet();
    endtask

    task automatic drive_op(input logic fp_op, input logic fp_we, input logic [4:0] rd,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                            input logic [2:0] um);
        id_valid = 1; id_fp_op = fp_op; id_fp_we = fp_we; id_fp_rd = rd;
        id_rs1 = r1; id_rs2 = r2; id_rs3 = r3; id_use = um;
    endtask

    task automatic apply_vec(input vec_t v);
        id_valid = v.v; id_fp_op = v.fp_op; id_fp_we = v.fp_we; id_fp_rd = v.rd;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs3 = v.rs3; id_use = v.use_m;
        flush = v.fl; fpu_busy = v.busy;
    endtask

    // A plain FP op with no sources/dest only stalls structurally, i.e. when BUSY.
    task automatic probe_state(input string name, input logic exp_busy);
        drive_op(1, 0, 5'd31, 0, 0, 0, 3'b000);
        #1;
        chk(name, 32'(stall), 32'(exp_busy));
        id_valid = 0; id_fp_op = 0;
    endtask

    function automatic vec_t mk(input logic v, input logic op, input logic we, input logic [4:0] rd,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                                input logic [2:0] um, input logic fl, input logic bz,
                                input logic ei, input logic es);
        vec_t r;
        r.v = v; r.fp_op = op; r.fp_we = we; r.rd = rd; r.rs1 = r1; r.rs2 = r2; r.rs3 = r3;
        r.use_m = um; r.fl = fl; r.busy = bz; r.exp_issue = ei; r.exp_stall = es;
        return r;
    endfunction

    // Every write-port use must match the oldest expected write-back.
    always @(negedge clk) begin
        if (!rst && wb_fp_we) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_fp_we), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_wb_rd", 32'(wb_fp_rd), 32'(e.rd));
                chk("sb_wb_sel", 32'(wb_sel_fpu), 32'(e.sel));
            end
        end
    end

    initial begin
        // IDLE vectors (0..4), then BUSY with pend_rd=f5 (5..13)
        vecs[0]  = mk(1, 1, 1, 3, 1, 2, 3, 3'b111, 0, 0, 1, 0);
        vecs[1]  = mk(1, 1, 1, 3, 1, 2, 3, 3'b111, 0, 1, 0, 1);
        vecs[2]  = mk(1, 1, 1, 3, 1, 2, 3, 3'b111, 1, 1, 0, 0);
        vecs[3]  = mk(1, 0, 1, 5, 0, 0, 0, 3'b000, 0, 1, 0, 0);
        vecs[4]  = mk(0, 1, 1, 3, 0, 0, 0, 3'b000, 0, 1, 0, 0);
        vecs[5]  = mk(1, 0, 1, 5, 0, 0, 0, 3'b000, 0, 1, 0, 1);
        vecs[6]  = mk(1, 0, 1, 4, 5, 5, 5, 3'b000, 0, 1, 0, 0);
        vecs[7]  = mk(1, 0, 1, 4, 0, 0, 5, 3'b100, 0, 1, 0, 1);
        vecs[8]  = mk(1, 0, 0, 5, 5, 0, 0, 3'b001, 0, 1, 0, 1);
        vecs[9]  = mk(1, 0, 1, 4, 1, 2, 3, 3'b111, 0, 1, 0, 0);
        vecs[10] = mk(1, 1, 1, 4, 1, 2, 3, 3'b111, 0, 1, 0, 1);
        vecs[11] = mk(1, 1, 1, 4, 1, 2, 3, 3'b111, 1, 1, 0, 0);
        vecs[12] = mk(1, 0, 0, 4, 0, 5, 0, 3'b010, 1, 1, 0, 0);
        vecs[13] = mk(1, 0, 0, 4, 0, 5, 0, 3'b010, 0, 1, 0, 1);

        quiet();
        rst = 1;
        int_wb_req = 1; int_wb_rd = 9;
        drive_op(1, 1, 2, 0, 0, 0, 3'b000);
        #3;
        chk("rst_issue", 32'(issue), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_we", 32'(wb_fp_we), 0);
        chk("rst_wb_rd", 32'(wb_fp_rd), 0);
        chk("rst_wb_sel", 32'(wb_sel_fpu), 0);
        chk("rst_gnt", 32'(int_wb_gnt), 0);
        chk("rst_wd_err", 32'(wd_err), 0);
        quiet();
        @(posedge clk); #1; rst = 0;

        for (int i = 0; i < 5; i++) begin
            next_cyc();
            apply_vec(vecs[i]);
            #2;
            chk($sformatf("vec%0d_issue", i), 32'(issue), 32'(vecs[i].exp_issue));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            quiet();
        end

        // issue fadd f5; completes four cycles later
        next_cyc();
        drive_op(1, 1, 5, 1, 2, 0, 3'b011);
        #1;
        chk("issue_f5", 32'(issue), 1);
        sb.push_back('{5'd5, 1'b1});

        next_cyc();
        for (int i = 5; i < 14; i++) begin
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d_issue", i), 32'(issue), 32'(vecs[i].exp_issue));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
        end
        quiet();

        // RAW on f5 through its completion cycle
        for (int c = 2; c <= 4; c++) begin
            next_cyc();
            drive_op(1, 1, 9, 0, 5, 0, 3'b010);
            if (c == 4) fpu_done = 1;
            #1;
            chk($sformatf("raw_stall_c%0d", c), 32'(stall), 1);
            chk($sformatf("raw_issue_c%0d", c), 32'(issue), 0);
            if (c == 4) begin
                chk("done_wb_we", 32'(wb_fp_we), 1);
                chk("done_wb_rd", 32'(wb_fp_rd), 5);
                chk("done_wb_sel", 32'(wb_sel_fpu), 1);
            end
        end
        next_cyc();
        drive_op(1, 1, 9, 0, 5, 0, 3'b010);
        #1;
        chk("raw_release_issue", 32'(issue), 1);
        chk("raw_release_stall", 32'(stall), 0);
        sb.push_back('{5'd9, 1'b1});

        // write-port conflict: FPU completion wins, integer write follows next cycle
        next_cyc();
        next_cyc();
        fpu_done = 1; int_wb_req = 1; int_wb_rd = 7;
        sb.push_back('{5'd7, 1'b0});
        #1;
        chk("conf_wb_rd", 32'(wb_fp_rd), 9);
        chk("conf_gnt", 32'(int_wb_gnt), 0);
        chk("conf_sel", 32'(wb_sel_fpu), 1);
        next_cyc();
        int_wb_req = 1; int_wb_rd = 7;
        #1;
        chk("conf2_gnt", 32'(int_wb_gnt), 1);
        chk("conf2_wb_rd", 32'(wb_fp_rd), 7);
        chk("conf2_sel", 32'(wb_sel_fpu), 0);
        chk("conf2_we", 32'(wb_fp_we), 1);
        probe_state("conf_idle", 0);

        // back-to-back issue on the completion cycle
        next_cyc();
        drive_op(1, 1, 5, 0, 0, 0, 3'b000);
        #1;
        chk("b2b_issue_f5", 32'(issue), 1);
        sb.push_back('{5'd5, 1'b1});
        next_cyc();
        next_cyc();
        fpu_done = 1;
        drive_op(1, 1, 6, 5, 0, 0, 3'b001);
        #1;
        chk("b2b_raw_stall", 32'(stall), 1);
        chk("b2b_raw_issue", 32'(issue), 0);
        drive_op(1, 1, 6, 1, 0, 0, 3'b001);
        #1;
        chk("b2b_issue_f6", 32'(issue), 1);
        chk("b2b_stall_f6", 32'(stall), 0);
        sb.push_back('{5'd6, 1'b1});
        next_cyc();
        probe_state("b2b_busy", 1);
        drive_op(0, 1, 6, 0, 0, 0, 3'b000);
        #1;
        chk("b2b_waw_f6", 32'(stall), 1);
        drive_op(0, 0, 4, 5, 0, 0, 3'b001);
        #1;
        chk("b2b_f5_free", 32'(stall), 0);
        quiet();
        next_cyc();
        fpu_done = 1;
        next_cyc();
        probe_state("b2b_idle", 0);

        // flush in IDLE, then flush while an older op is in flight
        next_cyc();
        drive_op(1, 1, 3, 0, 0, 0, 3'b000);
        flush = 1; fpu_busy = 1;
        #1;
        chk("flush_idle_issue", 32'(issue), 0);
        chk("flush_idle_stall", 32'(stall), 0);
        next_cyc();
        probe_state("flush_stays_idle", 0);
        next_cyc();
        drive_op(1, 1, 8, 0, 0, 0, 3'b000);
        #1;
        chk("issue_f8", 32'(issue), 1);
        sb.push_back('{5'd8, 1'b1});
        next_cyc();
        drive_op(1, 1, 2, 8, 0, 0, 3'b001);
        flush = 1;
        #1;
        chk("flush_busy_issue", 32'(issue), 0);
        chk("flush_busy_stall", 32'(stall), 0);
        next_cyc();
        fpu_done = 1;
        #1;
        chk("flush_wb_we", 32'(wb_fp_we), 1);
        chk("flush_wb_rd", 32'(wb_fp_rd), 8);

        // f0 is hazard-checked like any other register
        next_cyc();
        drive_op(1, 1, 0, 0, 0, 0, 3'b000);
        #1;
        chk("issue_f0", 32'(issue), 1);
        sb.push_back('{5'd0, 1'b1});
        next_cyc();
        drive_op(0, 0, 4, 0, 0, 0, 3'b001);
        #1;
        chk("f0_raw_stall", 32'(stall), 1);
        id_use = 3'b000;
        #1;
        chk("f0_unused_stall", 32'(stall), 0);
        next_cyc();
        fpu_done = 1;
        next_cyc();
        probe_state("f0_idle", 0);

        // watchdog: eight BUSY cycles without fpu_done
        next_cyc();
        drive_op(1, 1, 12, 0, 0, 0, 3'b000);
        #1;
        chk("issue_f12", 32'(issue), 1);
        for (int k = 1; k <= TO; k++) begin
            next_cyc();
            #1;
            chk($sformatf("wd_err_c%0d", k), 32'(wd_err), 0);
            if (k == TO) probe_state("wd_last_busy", 1);
        end
        next_cyc();
        #1;
        chk("wd_err_set", 32'(wd_err), 1);
        chk("wd_no_write", 32'(wb_fp_we), 0);
        probe_state("wd_idle", 0);
        next_cyc();
        fpu_done = 1;
        #1;
        chk("stray_done_we", 32'(wb_fp_we), 0);
        chk("wd_err_sticky", 32'(wd_err), 1);

        // asynchronous reset in the middle of a BUSY completion cycle
        next_cyc();
        drive_op(1, 1, 3, 0, 0, 0, 3'b000);
        next_cyc();
        fpu_done = 1;
        #1;
        chk("pre_rst_we", 32'(wb_fp_we), 1);
        rst = 1;
        #1;
        chk("async_rst_we", 32'(wb_fp_we), 0);
        chk("async_rst_rd", 32'(wb_fp_rd), 0);
        chk("async_rst_sel", 32'(wb_sel_fpu), 0);
        chk("async_rst_wd", 32'(wd_err), 0);
        fpu_done = 0;
        @(posedge clk); #1; rst = 0;
        next_cyc();
        probe_state("post_rst_idle", 0);

        next_cyc();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
